dfm_result_reader: RTL and testbench
====================================

# dfm_result_reader

Consumer end of the measurement result write port: captures each 64-bit `{ref_clk_sum, sig_clk_sum}` result pulse into a small FIFO and serves it to software through a read-only AXI4-Lite slave.
- Sits between the frequency measurement core and the AXI interconnect, in the core's clock domain.
- Buffers results so none are lost while software is slow, flags overflow, and raises a level interrupt while data is pending.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: result entries; power of two, 2..128.
- `ID_VALUE`, 32'h4446_4D31: constant returned at offset 0xC.

Ports:
- `clk_i` in 1: single clock for the block (same clock as the measurement core).
- `rst_i` in 1: reset, synchronous, active-high.
- `reg_wr_en_i` in 1: one-cycle result-valid pulse from the measurement core.
- `reg_wr_data_i` in 64: result; [31:0] = sig count sum, [63:32] = ref count sum.
- `s_axi_araddr` in 4: read address; [1:0] ignored.
- `s_axi_arvalid` in 1: AR valid.
- `s_axi_arready` out 1: AR ready.
- `s_axi_rdata` out 32: read data.
- `s_axi_rresp` out 2: 2'b00 OKAY, 2'b10 SLVERR.
- `s_axi_rvalid` out 1: R valid.
- `s_axi_rready` in 1: R ready.
- `irq_o` out 1: high while FIFO is not empty.

## Operation
- FIFO: `FIFO_DEPTH` x 64-bit, wrapping read/write pointers, count of width clog2(`FIFO_DEPTH`)+1.
  - Push on `reg_wr_en_i` when not full.
  - Push while full and no pop in the same cycle: data dropped, sticky `overflow` set.
  - Push and pop in the same cycle while full: both happen; count stays at `FIFO_DEPTH`; no overflow.
- Register map (offset = `araddr[3:2]`):
  - 0x0 STATUS: [7:0] count, [8] empty, [9] full, [10] overflow, rest 0. Reading STATUS clears overflow. If an overflow event occurs in the same cycle as the STATUS read, set wins.
  - 0x4 SIG: head entry [31:0]. No side effect.
  - 0x8 REF: head entry [63:32]. Pops the head.
  - 0xC ID: `ID_VALUE`.
  - SIG or REF read while empty: rdata = 0, rresp = SLVERR, no pop.
  - All other reads return OKAY.
- Read FSM:
  - IDLE: arready = 1, rvalid = 0. On `arvalid` the AR handshake completes. At that edge: rdata/rresp are registered from the pre-edge state, pop and overflow-clear side effects are applied, and the FSM moves to RESP.
  - RESP: arready = 0, rvalid = 1. rdata/rresp held stable until `rready`. On `rvalid & rready`, return to IDLE.
- `irq_o` = registered (count != 0).
- Software reads SIG before REF for each result.

## Timing
- Reset values: arready 0 during reset, 1 in the first cycle after reset; rvalid 0; rdata 0; rresp 0; irq_o 0; count 0; overflow 0; pointers 0.
- Reset mid-transaction aborts any pending response, drops R, and empties the FIFO.
- Push latency: count, STATUS and irq_o reflect a push on the cycle after the `reg_wr_en_i` edge.
- Read latency: rvalid rises the cycle after the AR handshake edge.
- Throughput: at most one read per 2 cycles (with rready tied high).
- Pop effect: a STATUS read issued on the cycle after a REF handshake sees the decremented count.
- Simultaneous push and REF read while empty: the read returns SLVERR, and the push lands (count = 1 next cycle).
- Pointer wrap-around: after index `FIFO_DEPTH`-1 the pointer returns to 0 with no gap or duplicate entry.

## Test plan
- Reset, then STATUS read -> rdata = 0x0000_0100 (empty), irq_o = 0; ID read -> 0x4446_4D31, OKAY.
- Push 0x0000_0002_0000_0001, then read SIG, REF -> 0x1, 0x2, OKAY; then STATUS -> 0x100, irq_o = 0.
- Push 9 results with DEPTH = 8 -> STATUS = 0x608 (count 8, full, overflow). Re-read STATUS -> 0x208. Drain 8 pairs -> first 8 values in order, then SIG returns SLVERR and 0.
- Push exactly on the REF-read handshake cycle while full -> count stays 8, no overflow, new entry is last out.
- Hold rready low for 5 cycles in RESP -> rdata/rresp stable, arready = 0, no second pop; release -> IDLE next cycle.
- 20 push/pop pairs (wrap twice) -> data order preserved; assert rst_i during RESP -> rvalid = 0 and count = 0 next cycle.

Source files
------------

// File: rtl/dfm_result_reader_if.sv
// Read-only AXI4-Lite channel bundle (AR + R) between the interconnect and the result reader.
interface dfm_result_reader_if;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport master (
    output s_axi_araddr,
    output s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata,
    input  s_axi_rresp,
    input  s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_araddr,
    input  s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata,
    output s_axi_rresp,
    output s_axi_rvalid,
    input  s_axi_rready
  );
endinterface

// File: rtl/dfm_result_reader.sv
// Buffers 64-bit {ref_sum, sig_sum} measurement results in a FIFO and serves them
// over a read-only AXI4-Lite slave; irq_o stays high while results are pending.
module dfm_result_reader #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] ID_VALUE   = 32'h4446_4D31
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      reg_wr_en_i,
  input  logic [63:0]               reg_wr_data_i,
  dfm_result_reader_if.slave        axi,
  output logic                      irq_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] A_STATUS = 2'd0;
  localparam logic [1:0] A_SIG    = 2'd1;
  localparam logic [1:0] A_REF    = 2'd2;
  localparam logic [1:0] A_ID     = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  function automatic logic [31:0] pack_status(input logic [CNT_W-1:0] cnt,
                                              input logic             empty,
                                              input logic             full,
                                              input logic             ovf);
    pack_status = {21'd0, ovf, full, empty, 8'(cnt)};
  endfunction

  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             irq_q;

  state_t           state_q, state_d;
  logic             arready_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic [63:0]      head;
  logic [1:0]       rd_sel;
  logic             ar_hs;
  logic             r_hs;
  logic             pop;
  logic             push;
  logic             ovf_evt;
  logic             status_rd;
  logic             unused_addr_lsb;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign head       = mem_q[rd_ptr_q];
  assign rd_sel     = axi.s_axi_araddr[3:2];
  assign ar_hs      = axi.s_axi_arvalid & arready_q;
  assign r_hs       = rvalid_q & axi.s_axi_rready;

  // Byte-lane bits of the address carry no meaning for 32-bit registers.
  assign unused_addr_lsb = ^axi.s_axi_araddr[1:0];

  // A REF read pops only if there is something to pop; an empty read is SLVERR instead.
  assign pop       = ar_hs & (rd_sel == A_REF) & ~fifo_empty;
  assign status_rd = ar_hs & (rd_sel == A_STATUS);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push      = reg_wr_en_i & (~fifo_full | pop);
  assign ovf_evt   = reg_wr_en_i & fifo_full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new overflow beats the clear-on-read of the same cycle.
    ovf_d = (ovf_q & ~status_rd) | ovf_evt;
  end

  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rresp_d = RESP_OKAY;
      unique case (rd_sel)
        A_STATUS: rdata_d = pack_status(count_q, fifo_empty, fifo_full, ovf_q);
        A_SIG: begin
          if (fifo_empty) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = head[31:0];
          end
        end
        A_REF: begin
          if (fifo_empty) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = head[63:32];
          end
        end
        A_ID:     rdata_d = ID_VALUE;
        default:  rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (ar_hs) state_d = S_RESP;
      S_RESP: if (r_hs)  state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  // Result storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= reg_wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irq_q     <= (count_d != '0);
      state_q   <= state_d;
      arready_q <= (state_d == S_IDLE);
      rvalid_q  <= (state_d == S_RESP);
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign axi.s_axi_arready = arready_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign irq_o             = irq_q;

endmodule

// File: tb/tb_dfm_result_reader.sv
// Directed bench for dfm_result_reader: register map, FIFO order, overflow, backpressure, reset.
module tb_dfm_result_reader;

  localparam logic [3:0] A_STATUS = 4'h0;
  localparam logic [3:0] A_SIG    = 4'h4;
  localparam logic [3:0] A_REF    = 4'h8;
  localparam logic [3:0] A_ID     = 4'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [63:0] wr_data;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;
  logic [1:0]  rr;

  always #5 clk = ~clk;

  dfm_result_reader_if axi_if ();

  dfm_result_reader #(
    .FIFO_DEPTH (8),
    .ID_VALUE   (32'h4446_4D31)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .reg_wr_en_i   (wr_en),
    .reg_wr_data_i (wr_data),
    .axi           (axi_if),
    .irq_o         (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    axi_if.s_axi_araddr  = a;
    axi_if.s_axi_arvalid = 1'b1;
    while (axi_if.s_axi_arready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL ar_timeout addr=%h arready=%b required 1", a, axi_if.s_axi_arready);
    end
    tick();
    axi_if.s_axi_arvalid = 1'b0;
    n = 0;
    while (axi_if.s_axi_rvalid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL r_timeout addr=%h rvalid=%b required 1", a, axi_if.s_axi_rvalid);
    end
    d = axi_if.s_axi_rdata;
    r = axi_if.s_axi_rresp;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0;
    axi_if.s_axi_araddr = '0; axi_if.s_axi_arvalid = 1'b0; axi_if.s_axi_rready = 1'b1;
    tick(); tick();
    checks++;
    if (axi_if.s_axi_arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", axi_if.s_axi_arready); end
    checks++;
    if (axi_if.s_axi_rvalid !== 1'b0 || axi_if.s_axi_rdata !== 32'h0 || axi_if.s_axi_rresp !== 2'b00) begin
      errors++; $display("FAIL rst_r got rvalid=%b rdata=%h rresp=%b want 0/0/0",
                         axi_if.s_axi_rvalid, axi_if.s_axi_rdata, axi_if.s_axi_rresp);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
    rst = 1'b0;
    tick();
    checks++;
    if (axi_if.s_axi_arready !== 1'b1) begin errors++; $display("FAIL post_rst_arready got %b want 1", axi_if.s_axi_arready); end
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0100 || rr !== 2'b00) begin errors++; $display("FAIL rst_status got %h/%b want 00000100/00", rd, rr); end
    axi_read(A_ID, rd, rr);
    checks++;
    if (rd !== 32'h4446_4D31 || rr !== 2'b00) begin errors++; $display("FAIL id got %h/%b want 44464d31/00", rd, rr); end
  endtask

  task automatic test_single();
    push(64'h0000_0002_0000_0001);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got %b want 1", irq); end
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL single_status1 got %h want 00000001", rd); end
    axi_read(A_SIG, rd, rr);
    checks++;
    if (rd !== 32'h1 || rr !== 2'b00) begin errors++; $display("FAIL single_sig got %h/%b want 00000001/00", rd, rr); end
    axi_read(A_REF, rd, rr);
    checks++;
    if (rd !== 32'h2 || rr !== 2'b00) begin errors++; $display("FAIL single_ref got %h/%b want 00000002/00", rd, rr); end
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0100) begin errors++; $display("FAIL single_status2 got %h want 00000100", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_clr got %b want 0", irq); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      wr_en   = 1'b1;
      wr_data = {32'h200 + 32'(i), 32'h100 + 32'(i)};
      tick();
    end
    wr_en = 1'b0;
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0608) begin errors++; $display("FAIL ovf_status got %h want 00000608", rd); end
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0208) begin errors++; $display("FAIL ovf_clear got %h want 00000208", rd); end
    for (int i = 0; i < 8; i++) begin
      axi_read(A_SIG, rd, rr);
      checks++;
      if (rd !== 32'h100 + 32'(i) || rr !== 2'b00) begin
        errors++; $display("FAIL ovf_drain_sig[%0d] got %h/%b want %h/00", i, rd, rr, 32'h100 + 32'(i));
      end
      axi_read(A_REF, rd, rr);
      checks++;
      if (rd !== 32'h200 + 32'(i) || rr !== 2'b00) begin
        errors++; $display("FAIL ovf_drain_ref[%0d] got %h/%b want %h/00", i, rd, rr, 32'h200 + 32'(i));
      end
    end
    axi_read(A_SIG, rd, rr);
    checks++;
    if (rd !== 32'h0 || rr !== 2'b10) begin errors++; $display("FAIL empty_sig got %h/%b want 00000000/10", rd, rr); end
    axi_read(A_REF, rd, rr);
    checks++;
    if (rd !== 32'h0 || rr !== 2'b10) begin errors++; $display("FAIL empty_ref got %h/%b want 00000000/10", rd, rr); end
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0100) begin errors++; $display("FAIL empty_status got %h want 00000100", rd); end
  endtask

  task automatic test_ovf_set_wins();
    for (int i = 0; i < 8; i++) push({32'h500 + 32'(i), 32'h400 + 32'(i)});
    axi_if.s_axi_araddr  = A_STATUS;
    axi_if.s_axi_arvalid = 1'b1;
    wr_en   = 1'b1;
    wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    axi_if.s_axi_arvalid = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (axi_if.s_axi_rvalid !== 1'b1 || axi_if.s_axi_rdata !== 32'h0000_0208) begin
      errors++; $display("FAIL setwins_read got rvalid=%b rdata=%h want 1/00000208",
                         axi_if.s_axi_rvalid, axi_if.s_axi_rdata);
    end
    tick();
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0608) begin errors++; $display("FAIL setwins_ovf got %h want 00000608", rd); end
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0208) begin errors++; $display("FAIL setwins_clear got %h want 00000208", rd); end
  endtask

  task automatic test_full_push_pop();
    axi_if.s_axi_araddr  = A_REF;
    axi_if.s_axi_arvalid = 1'b1;
    wr_en   = 1'b1;
    wr_data = {32'h5FF, 32'h4FF};
    tick();
    axi_if.s_axi_arvalid = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (axi_if.s_axi_rdata !== 32'h500 || axi_if.s_axi_rresp !== 2'b00) begin
      errors++; $display("FAIL fpp_ref got %h/%b want 00000500/00", axi_if.s_axi_rdata, axi_if.s_axi_rresp);
    end
    tick();
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0208) begin errors++; $display("FAIL fpp_status got %h want 00000208", rd); end
    for (int j = 0; j < 8; j++) begin
      logic [31:0] es;
      logic [31:0] er;
      es = (j < 7) ? 32'h401 + 32'(j) : 32'h4FF;
      er = (j < 7) ? 32'h501 + 32'(j) : 32'h5FF;
      axi_read(A_SIG, rd, rr);
      checks++;
      if (rd !== es) begin errors++; $display("FAIL fpp_sig[%0d] got %h want %h", j, rd, es); end
      axi_read(A_REF, rd, rr);
      checks++;
      if (rd !== er) begin errors++; $display("FAIL fpp_ref[%0d] got %h want %h", j, rd, er); end
    end
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0100) begin errors++; $display("FAIL fpp_empty got %h want 00000100", rd); end
  endtask

  task automatic test_backpressure();
    push({32'hA01, 32'hB01});
    push({32'hA02, 32'hB02});
    axi_if.s_axi_rready  = 1'b0;
    axi_if.s_axi_araddr  = A_REF;
    axi_if.s_axi_arvalid = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (axi_if.s_axi_rvalid !== 1'b1 || axi_if.s_axi_arready !== 1'b0 ||
          axi_if.s_axi_rdata !== 32'hA01 || axi_if.s_axi_rresp !== 2'b00) begin
        errors++; $display("FAIL hold[%0d] got rvalid=%b arready=%b rdata=%h rresp=%b want 1/0/00000a01/00",
                           k, axi_if.s_axi_rvalid, axi_if.s_axi_arready, axi_if.s_axi_rdata, axi_if.s_axi_rresp);
      end
      tick();
    end
    axi_if.s_axi_arvalid = 1'b0;
    axi_if.s_axi_rready  = 1'b1;
    tick();
    checks++;
    if (axi_if.s_axi_rvalid !== 1'b0 || axi_if.s_axi_arready !== 1'b1) begin
      errors++; $display("FAIL release got rvalid=%b arready=%b want 0/1", axi_if.s_axi_rvalid, axi_if.s_axi_arready);
    end
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL hold_single_pop got %h want 00000001", rd); end
    axi_read(A_SIG, rd, rr);
    checks++;
    if (rd !== 32'hB02) begin errors++; $display("FAIL hold_next_sig got %h want 00000b02", rd); end
    axi_read(A_REF, rd, rr);
    checks++;
    if (rd !== 32'hA02) begin errors++; $display("FAIL hold_next_ref got %h want 00000a02", rd); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      push({32'hC000 + 32'(i), 32'hD000 + 32'(i)});
      axi_read(A_SIG, rd, rr);
      checks++;
      if (rd !== 32'hD000 + 32'(i)) begin errors++; $display("FAIL wrap_sig[%0d] got %h want %h", i, rd, 32'hD000 + 32'(i)); end
      axi_read(A_REF, rd, rr);
      checks++;
      if (rd !== 32'hC000 + 32'(i)) begin errors++; $display("FAIL wrap_ref[%0d] got %h want %h", i, rd, 32'hC000 + 32'(i)); end
    end
  endtask

  task automatic test_empty_push_ref();
    axi_if.s_axi_araddr  = A_REF;
    axi_if.s_axi_arvalid = 1'b1;
    wr_en   = 1'b1;
    wr_data = {32'hE2, 32'hE1};
    tick();
    axi_if.s_axi_arvalid = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (axi_if.s_axi_rdata !== 32'h0 || axi_if.s_axi_rresp !== 2'b10) begin
      errors++; $display("FAIL epr_resp got %h/%b want 00000000/10", axi_if.s_axi_rdata, axi_if.s_axi_rresp);
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL epr_irq got %b want 1", irq); end
    tick();
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL epr_status got %h want 00000001", rd); end
  endtask

  task automatic test_reset_mid();
    push({32'hF2, 32'hF1});
    axi_if.s_axi_rready  = 1'b0;
    axi_if.s_axi_araddr  = A_SIG;
    axi_if.s_axi_arvalid = 1'b1;
    tick();
    axi_if.s_axi_arvalid = 1'b0;
    checks++;
    if (axi_if.s_axi_rvalid !== 1'b1) begin errors++; $display("FAIL mid_resp got rvalid=%b want 1", axi_if.s_axi_rvalid); end
    rst = 1'b1;
    tick();
    checks++;
    if (axi_if.s_axi_rvalid !== 1'b0 || irq !== 1'b0 || axi_if.s_axi_arready !== 1'b0) begin
      errors++; $display("FAIL mid_rst got rvalid=%b irq=%b arready=%b want 0/0/0",
                         axi_if.s_axi_rvalid, irq, axi_if.s_axi_arready);
    end
    rst = 1'b0;
    axi_if.s_axi_rready = 1'b1;
    tick();
    axi_read(A_STATUS, rd, rr);
    checks++;
    if (rd !== 32'h0000_0100) begin errors++; $display("FAIL mid_status got %h want 00000100", rd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_ovf_set_wins();
    test_full_push_pop();
    test_backpressure();
    test_wrap();
    test_empty_push_ref();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
